// File: rtl/mult4u_dmr_sched.sv
// Two-requester scheduler for one shared 4x4 unsigned multiplier. Every product is
// computed twice with swapped operands, and the pair is re-run up to MAX_RETRY times if the two results disagree.
module mult4u_dmr_sched #(
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic [3:0] mult_a,
    output logic [3:0] mult_b,
    input  logic [7:0] mult_p,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_p,
    output logic       rsp_err,
    output logic [7:0] mismatch_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN1 = 2'd1,
        RUN2 = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

    state_t     state_r, state_s;
    logic [3:0] a_r, b_r;
    logic       id_r;
    logic       last_r;
    logic [7:0] p1_r;
    logic [2:0] retry_r;
    logic       grant_s, gid_s, match_s, retry_ok_s;

    // Next-state, arbitration and multiplier operand decode
    always_comb begin
        state_s    = state_r;
        grant_s    = 1'b0;
        gid_s      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mult_a     = 4'd0;
        mult_b     = 4'd0;
        match_s    = (mult_p == p1_r);
        retry_ok_s = (retry_r < MAX_RETRY_C);
        case (state_r)
            IDLE: begin
                // rst gating keeps ready low while reset is held between edges
                if (!rst && (req0_valid || req1_valid)) begin
                    grant_s = 1'b1;
                    if (req0_valid && req1_valid) begin
                        gid_s = ~last_r;
                    end else begin
                        gid_s = req1_valid;
                    end
                    req0_ready = ~gid_s;
                    req1_ready = gid_s;
                    state_s    = RUN1;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN1: begin
                mult_a  = a_r;
                mult_b  = b_r;
                state_s = RUN2;
            end
            RUN2: begin
                // Swapped operands exercise different multiplier input pins
                mult_a = b_r;
                mult_b = a_r;
                if (!match_s && retry_ok_s) begin
                    state_s = RUN1;
                end else begin
                    state_s = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    assign rsp_valid = (state_r == RESP);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, first-pass product, retry bookkeeping and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r          <= 4'd0;
            b_r          <= 4'd0;
            id_r         <= 1'b0;
            last_r       <= 1'b1;
            p1_r         <= 8'd0;
            retry_r      <= 3'd0;
            rsp_id       <= 1'b0;
            rsp_p        <= 8'd0;
            rsp_err      <= 1'b0;
            mismatch_cnt <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        a_r     <= gid_s ? req1_a : req0_a;
                        b_r     <= gid_s ? req1_b : req0_b;
                        id_r    <= gid_s;
                        last_r  <= gid_s;
                        retry_r <= 3'd0;
                    end
                end
                RUN1: p1_r <= mult_p;
                RUN2: begin
                    if (match_s) begin
                        rsp_id  <= id_r;
                        rsp_p   <= p1_r;
                        rsp_err <= 1'b0;
                    end else begin
                        if (mismatch_cnt != 8'hFF) begin
                            mismatch_cnt <= mismatch_cnt + 8'd1;
                        end
                        if (retry_ok_s) begin
                            retry_r <= retry_r + 3'd1;
                        end else begin
                            rsp_id  <= id_r;
                            rsp_p   <= p1_r;
                            rsp_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mult4u_dmr_sched.md
MULT4U_DMR_SCHED -- requirements
Module: mult4u_dmr_sched

Interface
REQ-001 Parameter: MAX_RETRY, default 3, number of re-executions allowed after a result mismatch (range 0..7).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has an operand pair pending.
REQ-005 Port: req0_a, req0_b  input  4 each  requester 0 unsigned operands.
REQ-006 Port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 Port: req1_valid / req1_a / req1_b / req1_ready  same widths and meaning for requester 1.
REQ-008 Port: mult_a, mult_b  output  4 each  operands driven to the shared combinational 4x4 unsigned multiplier.
REQ-009 Port: mult_p  input  8  product returned by the shared multiplier, valid in the same cycle.
REQ-010 Port: rsp_valid  output  1  result available.
REQ-011 Port: rsp_ready  input  1  consumer accepts result.
REQ-012 Port: rsp_id  output  1  requester that owns the result.
REQ-013 Port: rsp_p  output  8  product.
REQ-014 Port: rsp_err  output  1  product unconfirmed; retries exhausted.
REQ-015 Port: mismatch_cnt  output  8  saturating count of all detected mismatches since reset.

Function
REQ-016 The FSM SHALL have states IDLE, RUN1, RUN2, RESP.
REQ-017 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally for that cycle only, latch its operands and id, clear the retry counter, go to RUN1.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; the last-grant pointer updates only on a grant.
REQ-019 reqN_ready SHALL be 0 in every state other than IDLE, and at most one ready SHALL be high in any cycle.
REQ-020 RUN1: mult_a=A, mult_b=B; capture mult_p into P1 at the clock edge; go to RUN2.
REQ-021 RUN2: mult_a=B, mult_b=A (swapped, for input-pin fault diversity); compare mult_p with P1 at the clock edge.
REQ-022 On match: rsp_p<=P1, rsp_err<=0, go to RESP.
REQ-023 On mismatch: mismatch_cnt increments, saturating at 255; if retry count < MAX_RETRY, increment it and go to RUN1, else rsp_p<=P1, rsp_err<=1, go to RESP.
REQ-024 mult_a and mult_b SHALL be 0 in IDLE and RESP.
REQ-025 RESP: rsp_valid=1 with rsp_id, rsp_p and rsp_err held stable; on rsp_ready=1 go to IDLE and deassert rsp_valid the next cycle.
REQ-026 A new grant SHALL NOT occur in the cycle RESP completes; the earliest next grant is the following IDLE cycle.
REQ-027 Latency, fault-free: grant in cycle T, rsp_valid first high in cycle T+3; each retry adds 2 cycles.
REQ-028 Requester inputs changing after the grant SHALL NOT affect the in-flight operation.
REQ-029 MAX_RETRY=0: the first mismatch SHALL go directly to RESP with rsp_err=1.

Reset
REQ-030 While rst=1, regardless of clock: state=IDLE, reqN_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, rsp_err=0, mult_a=mult_b=0, mismatch_cnt=0, retry count=0, last-grant pointer set so requester 0 wins the first tie.
REQ-031 Reset asserted mid-operation SHALL abort it with no response issued; the first grant after reset deassertion SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-032 Single request: req0 A=13, B=11, ideal multiplier, rsp_ready=1 -> req0_ready high in T, rsp_valid in T+3 with rsp_p=143, rsp_id=0, rsp_err=0, mismatch_cnt=0.
REQ-033 Tie arbitration: both valid continuously (req0 3x5, req1 15x15) -> grants alternate 0,1,0 after reset, responses 15, 225, 15 with matching rsp_id.
REQ-034 Transient fault: corrupt mult_p to 0x00 in the first RUN2 cycle only, A=7, B=9 -> one retry, rsp_p=63, rsp_err=0, mismatch_cnt=1, rsp_valid at T+5.
REQ-035 Stuck mult_a bit 0 at 1, A=2, B=4, MAX_RETRY=3 -> 4 mismatches, rsp_err=1, rsp_p=12, mismatch_cnt=4.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP with req1 valid -> rsp fields stable, req1_ready stays 0, req1 granted one cycle after the rsp handshake.
REQ-037 Reset mid-RUN2 -> all outputs at reset values asynchronously, no rsp_valid, next request completes normally.
